// File: rtl/mem_pipe_rw_if.sv
// rtl/mem_pipe_rw_if.sv - request/response bundle for the pipelined read/write memory
interface mem_pipe_rw_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wr_en;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rd_valid;
  logic                    err;
  logic                    ready;

  modport master (
    output addr, wr_en, rd_en, wdata, be,
    input  rdata, rd_valid, err, ready
  );

  modport slave (
    input  addr, wr_en, rd_en, wdata, be,
    output rdata, rd_valid, err, ready
  );
endinterface

// File: rtl/mem_pipe_rw.sv
// rtl/mem_pipe_rw.sv - single-port memory with byte enables, read pipeline and post-reset clear
module mem_pipe_rw #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mem_pipe_rw_if.slave  bus
);
  localparam int                    NB       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_init_ptr;
  logic [ADDR_WIDTH-1:0]   w_init_ptr_nxt;
  logic                    w_ready;
  logic                    w_init_wr;
  logic                    w_in_range;
  logic                    w_rd_acc;
  logic                    w_wr_acc;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    r_pv [RD_LATENCY];
  logic                    r_pe [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   r_pd [RD_LATENCY];

  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_rd_valid;
  logic                    r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  // INIT sweeps every location once; IDLE is only left through reset
  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    w_ready        = 1'b0;
    w_init_wr      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_wr      = 1'b1;
        w_init_ptr_nxt = r_init_ptr + 1'b1;
        if (r_init_ptr == LP_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_init_ptr_nxt = '0;
        end
      end
      ST_IDLE: w_ready = 1'b1;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_in_range = ({1'b0, bus.addr} < LP_DEPTH);
  assign w_rd_acc   = w_ready & bus.rd_en;
  assign w_wr_acc   = w_ready & bus.wr_en;

  always_ff @(posedge i_clk) begin
    if (w_init_wr && !i_reset) begin
      r_mem[r_init_ptr] <= '0;
    end else if (w_wr_acc && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.be[b]) r_mem[bus.addr][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < RD_LATENCY; k++) r_pv[k] <= 1'b0;
    end else begin
      r_pv[0] <= w_rd_acc;
      for (int k = 1; k < RD_LATENCY; k++) r_pv[k] <= r_pv[k-1];
    end
  end

  // Stage 0 samples the array before this edge's write lands: read-before-write
  always_ff @(posedge i_clk) begin
    r_pd[0] <= w_in_range ? r_mem[bus.addr] : '0;
    r_pe[0] <= ~w_in_range;
    for (int k = 1; k < RD_LATENCY; k++) begin
      r_pd[k] <= r_pd[k-1];
      r_pe[k] <= r_pe[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= r_pv[RD_LATENCY-1];
      if (r_pv[RD_LATENCY-1]) r_rdata <= r_pd[RD_LATENCY-1];
      r_err <= (w_wr_acc & ~w_in_range) | (r_pv[RD_LATENCY-1] & r_pe[RD_LATENCY-1]);
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.rd_valid = r_rd_valid;
  assign bus.err      = r_err;
  assign bus.ready    = w_ready;
endmodule

// File: tb/tb_mem_pipe_rw.sv
// tb/tb_mem_pipe_rw.sv - bench for mem_pipe_rw at read latencies 1, 2 and 4
module tb_mem_pipe_rw;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int DEP = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  be;

  logic [15:0] s_rdata [3];
  logic        s_vld   [3];
  logic        s_err   [3];
  logic        s_rdy   [3];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      mem_pipe_rw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
      assign bus.addr  = addr;
      assign bus.wr_en = wr;
      assign bus.rd_en = rd;
      assign bus.wdata = wdata;
      assign bus.be    = be;
      mem_pipe_rw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RD_LATENCY(L)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
      );
      assign s_rdata[g] = bus.rdata;
      assign s_vld[g]   = bus.rd_valid;
      assign s_err[g]   = bus.err;
      assign s_rdy[g]   = bus.ready;
    end
  endgenerate

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          err;
  } resp_t;

  typedef struct {
    bit          w;
    bit          r;
    logic [3:0]  a;
    logic [15:0] d;
    logic [1:0]  b;
    bit          ev;
    bit          ee;
    logic [15:0] ed;
  } vec_t;

  resp_t       rq [3][$];
  logic [15:0] m_mem [DEP];
  logic [15:0] m_last [3];
  bit          m_ready;
  int          m_cnt;
  int          cyc;
  int          n_pass;
  int          n_tot;
  vec_t        tv [26];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic model_check(input bit r, input bit w, input bit rr, input logic [3:0] a,
                             input logic [15:0] d, input logic [1:0] b);
    bit wr_err;
    bit v;
    bit e;
    wr_err = 1'b0;
    if (r) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int k = 0; k < 3; k++) begin
        rq[k].delete();
        m_last[k] = 16'h0;
      end
      for (int i = 0; i < DEP; i++) m_mem[i] = 16'h0;
    end else begin
      if (m_ready && rr) begin
        for (int k = 0; k < 3; k++)
          rq[k].push_back('{cyc + lat_of(k), (int'(a) < DEP) ? m_mem[a] : 16'h0, int'(a) >= DEP});
      end
      if (m_ready && w) begin
        if (int'(a) < DEP) begin
          if (b[0]) m_mem[a][7:0]  = d[7:0];
          if (b[1]) m_mem[a][15:8] = d[15:8];
        end else begin
          wr_err = 1'b1;
        end
      end
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == DEP) m_ready = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      v = (rq[k].size() > 0) && (rq[k][0].due == cyc);
      e = wr_err;
      if (v) begin
        e = e | rq[k][0].err;
        m_last[k] = rq[k][0].data;
        void'(rq[k].pop_front());
      end
      chk($sformatf("ready_L%0d", lat_of(k)), 32'(s_rdy[k]), 32'(m_ready));
      chk($sformatf("rd_valid_L%0d", lat_of(k)), 32'(s_vld[k]), 32'(v));
      chk($sformatf("err_L%0d", lat_of(k)), 32'(s_err[k]), 32'(e));
      chk($sformatf("rdata_L%0d", lat_of(k)), 32'(s_rdata[k]), 32'(m_last[k]));
    end
  endtask

  task automatic step(input bit r, input bit w, input bit rr, input logic [3:0] a,
                      input logic [15:0] d, input logic [1:0] b);
    rst = r; wr = w; rd = rr; addr = a; wdata = d; be = b;
    @(posedge clk);
    #1;
    cyc++;
    model_check(r, w, rr, a, d, b);
  endtask

  task automatic wait_ready();
    int  edges;
    bit  seen;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
      edges++;
      if (s_rdy[1]) seen = 1'b1;
    end
    chk("ready_edges_after_reset", 32'(edges), 32'(DEP));
  endtask

  task automatic set_v(input int i, input bit w, input bit r, input int a, input int d,
                       input int b, input bit ev, input bit ee, input int ed);
    tv[i].w  = w;
    tv[i].r  = r;
    tv[i].a  = 4'(a);
    tv[i].d  = 16'(d);
    tv[i].b  = 2'(b);
    tv[i].ev = ev;
    tv[i].ee = ee;
    tv[i].ed = 16'(ed);
  endtask

  task automatic read_all_and_drain();
    for (int a = 0; a < DEP; a++) step(1'b0, 1'b0, 1'b1, 4'(a), 16'h0, 2'b00);
    repeat (5) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    cyc    = 0;
    m_ready = 1'b0;
    m_cnt   = 0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; be = '0;

    // Expectations below are for the latency-2 instance
    set_v( 0, 1, 0,  5, 'hA1B2, 3, 0, 0, 0);
    set_v( 1, 1, 0,  5, 'hFFFF, 1, 0, 0, 0);
    set_v( 2, 1, 0,  5, 'h1234, 0, 0, 0, 0);
    set_v( 3, 0, 1,  5, 0,      0, 0, 0, 0);
    set_v( 4, 1, 0,  7, 'h5555, 3, 0, 0, 0);
    set_v( 5, 1, 1,  7, 'hAAAA, 3, 1, 0, 'hA1FF);
    set_v( 6, 0, 1,  7, 0,      0, 0, 0, 0);
    set_v( 7, 0, 0,  0, 0,      0, 1, 0, 'h5555);
    set_v( 8, 0, 0,  0, 0,      0, 1, 0, 'hAAAA);
    set_v( 9, 1, 0, 13, 'hDEAD, 3, 0, 1, 0);
    set_v(10, 0, 1, 14, 0,      0, 0, 0, 0);
    set_v(11, 0, 0,  0, 0,      0, 0, 0, 0);
    set_v(12, 0, 0,  0, 0,      0, 1, 1, 0);
    set_v(13, 1, 0,  0, 'h0010, 3, 0, 0, 0);
    set_v(14, 1, 0,  1, 'h0011, 3, 0, 0, 0);
    set_v(15, 1, 0,  2, 'h0012, 3, 0, 0, 0);
    set_v(16, 1, 0,  3, 'h0013, 3, 0, 0, 0);
    set_v(17, 0, 1,  0, 0,      0, 0, 0, 0);
    set_v(18, 0, 1,  1, 0,      0, 0, 0, 0);
    set_v(19, 0, 1,  2, 0,      0, 1, 0, 'h0010);
    set_v(20, 0, 1,  3, 0,      0, 1, 0, 'h0011);
    set_v(21, 0, 0,  0, 0,      0, 1, 0, 'h0012);
    set_v(22, 0, 0,  0, 0,      0, 1, 0, 'h0013);
    set_v(23, 0, 1,  1, 0,      0, 0, 0, 0);
    set_v(24, 0, 0,  0, 0,      0, 0, 0, 0);
    set_v(25, 0, 0,  0, 0,      0, 1, 0, 'h0011);

    repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    wait_ready();
    read_all_and_drain();

    for (int i = 0; i < 26; i++) begin
      step(1'b0, tv[i].w, tv[i].r, tv[i].a, tv[i].d, tv[i].b);
      chk($sformatf("vec%0d_rd_valid", i), 32'(s_vld[1]), 32'(tv[i].ev));
      chk($sformatf("vec%0d_err", i), 32'(s_err[1]), 32'(tv[i].ee));
      if (tv[i].ev) chk($sformatf("vec%0d_rdata", i), 32'(s_rdata[1]), 32'(tv[i].ed));
    end

    // Two reads in flight when reset arrives must never surface
    step(1'b0, 1'b0, 1'b1, 4'd5, 16'h0, 2'b00);
    step(1'b0, 1'b0, 1'b1, 4'd7, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
      chk("midreset_no_rd_valid", 32'(s_vld[1]), 32'd0);
    end
    wait_ready();
    read_all_and_drain();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom),
           4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
